// File: rtl/instr_decoder_pkg.sv
// Shared encodings, state codes and pure decode helpers for the registered
// ARM-subset instruction decoder.
package instr_decoder_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [2:0] CLS_DP_REG = 3'b000;
  localparam logic [2:0] CLS_DP_IMM = 3'b001;
  localparam logic [2:0] CLS_LS_IMM = 3'b010;
  localparam logic [2:0] CLS_LS_REG = 3'b011;
  localparam logic [2:0] CLS_BRANCH = 3'b101;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_ANDS = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SUBS = 5'b00101;
  localparam logic [4:0] OP_ADD  = 5'b01000;
  localparam logic [4:0] OP_ADDS = 5'b01001;
  localparam logic [4:0] OP_MOVT = 5'b10100;
  localparam logic [4:0] OP_ORR  = 5'b11000;
  localparam logic [4:0] OP_MOV  = 5'b11010;
  localparam logic [4:0] OP_MOVS = 5'b11011;

  localparam logic [6:0] ST_ADD_RR   = 7'd5;
  localparam logic [6:0] ST_ADD_RSH  = 7'd6;
  localparam logic [6:0] ST_ADD_IMM  = 7'd7;
  localparam logic [6:0] ST_MOVT_IMM = 7'd8;
  localparam logic [6:0] ST_MOV_IMM  = 7'd9;
  localparam logic [6:0] ST_ADDS_RR  = 7'd10;
  localparam logic [6:0] ST_ADDS_RSH = 7'd11;
  localparam logic [6:0] ST_ADDS_IMM = 7'd12;
  localparam logic [6:0] ST_MOVS_IMM = 7'd13;
  localparam logic [6:0] ST_B        = 7'd30;
  localparam logic [6:0] ST_BL       = 7'd31;
  localparam logic [6:0] ST_ORR_IMM  = 7'd123;
  localparam logic [6:0] ST_SUBS_IMM = 7'd124;
  localparam logic [6:0] ST_SUB_IMM  = 7'd125;
  localparam logic [6:0] ST_ANDS_IMM = 7'd126;
  localparam logic [6:0] ST_AND_IMM  = 7'd127;

  localparam logic [6:0] LS_IMM_PRE   = 7'd122;
  localparam logic [6:0] LS_IMM_PREWB = 7'd114;
  localparam logic [6:0] LS_IMM_POST  = 7'd106;
  localparam logic [6:0] LS_REG_PRE   = 7'd90;
  localparam logic [6:0] LS_REG_PREWB = 7'd82;
  localparam logic [6:0] LS_REG_POST  = 7'd74;

  typedef struct packed {
    logic [6:0] state;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t       d;
    logic [6:0] base;
    logic [4:0] op;
    d.state   = 7'd0;
    d.illegal = 1'b1;
    base      = 7'd0;
    op        = instr[24:20];
    case (instr[27:25])
      CLS_DP_REG: begin
        if (!instr[4] && (op == OP_ADD)) begin
          d.state   = (instr[11:5] == 7'd0) ? ST_ADD_RR : ST_ADD_RSH;
          d.illegal = 1'b0;
        end else if (!instr[4] && (op == OP_ADDS)) begin
          d.state   = (instr[11:5] == 7'd0) ? ST_ADDS_RR : ST_ADDS_RSH;
          d.illegal = 1'b0;
        end else begin
          d.state   = 7'd0;
          d.illegal = 1'b1;
        end
      end
      CLS_DP_IMM: begin
        d.illegal = 1'b0;
        case (op)
          OP_ADD:  d.state = ST_ADD_IMM;
          OP_ADDS: d.state = ST_ADDS_IMM;
          OP_MOVT: d.state = ST_MOVT_IMM;
          OP_MOV:  d.state = ST_MOV_IMM;
          OP_MOVS: d.state = ST_MOVS_IMM;
          OP_AND:  d.state = ST_AND_IMM;
          OP_ANDS: d.state = ST_ANDS_IMM;
          OP_SUB:  d.state = ST_SUB_IMM;
          OP_SUBS: d.state = ST_SUBS_IMM;
          OP_ORR:  d.state = ST_ORR_IMM;
          default: begin
            d.state   = 7'd0;
            d.illegal = 1'b1;
          end
        endcase
      end
      CLS_LS_IMM, CLS_LS_REG: begin
        // Register-offset forms with bit4 set are media/extension space.
        if (instr[25] && instr[4]) begin
          d.state   = 7'd0;
          d.illegal = 1'b1;
        end else begin
          if (!instr[24]) begin
            base = instr[25] ? LS_REG_POST : LS_IMM_POST;
          end else if (instr[21]) begin
            base = instr[25] ? LS_REG_PREWB : LS_IMM_PREWB;
          end else begin
            base = instr[25] ? LS_REG_PRE : LS_IMM_PRE;
          end
          d.state   = base - {4'd0, instr[23:22], 1'b0} - {6'd0, ~instr[20]};
          d.illegal = 1'b0;
        end
      end
      CLS_BRANCH: begin
        d.state   = instr[24] ? ST_BL : ST_B;
        d.illegal = 1'b0;
      end
      default: begin
        d.state   = 7'd0;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

  // flags are packed N,Z,C,V from bit 3 down to bit 0.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, pass;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/instr_decoder_pipe_skid_buf.sv
// Two-entry ready/valid buffer: an output register plus one skid slot, so the
// upstream ready depends only on registered state and the flush request.
module decoder_skid_buf #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] out_data_r;
  logic [W-1:0] skid_data_r;
  logic         out_valid_r;
  logic         skid_valid_r;
  logic         push_s;

  assign in_ready  = !skid_valid_r && !flush;
  assign push_s    = in_valid && in_ready;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;

  // Output slot refills from the skid slot first so ordering is preserved.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r   <= '0;
      skid_data_r  <= '0;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (!out_valid_r || out_ready) begin
      if (skid_valid_r) begin
        out_data_r   <= skid_data_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (push_s) begin
        out_data_r  <= in_data;
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (push_s) begin
      skid_data_r  <= in_data;
      skid_valid_r <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_decoder_pipe.sv
// Registered instruction-to-state decoder with condition evaluation, illegal
// detection, skid-buffered handshake and saturating statistics counters.
module instr_decoder_pipe
  import instr_decoder_pkg::*;
#(
  parameter int unsigned STATE_W      = 7,
  parameter int unsigned NOP_CODE     = 1,
  parameter int unsigned ILLEGAL_CODE = 0,
  parameter int unsigned COND_EN      = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [31:0]        in_instr,
  input  logic [3:0]         in_flags,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               out_cond_pass,
  output logic               out_illegal,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   decode_count,
  output logic [CNT_W-1:0]   illegal_count
);

  if (STATE_W < 7) begin : g_state_w_check
    $error("instr_decoder_pipe: STATE_W must be at least 7");
  end

  localparam int unsigned         PW          = STATE_W + 2;
  localparam logic [STATE_W-1:0]  NOP_STATE   = STATE_W'(NOP_CODE);
  localparam logic [STATE_W-1:0]  ILL_STATE   = STATE_W'(ILLEGAL_CODE);
  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);

  dec_t               dec_s;
  logic               nv_s;
  logic               pass_s;
  logic [STATE_W-1:0] state_s;
  logic               cond_pass_s;
  logic               illegal_s;
  logic [PW-1:0]      out_data_s;
  logic               xfer_s;
  logic [CNT_W-1:0]   dec_cnt_r;
  logic [CNT_W-1:0]   ill_cnt_r;

  // Decode and condition check; illegal outranks a failed condition.
  always_comb begin
    dec_s       = decode_instr(in_instr);
    nv_s        = (COND_EN != 0) && (in_instr[31:28] == COND_NV);
    pass_s      = (COND_EN != 0) ? cond_check(in_instr[31:28], in_flags) : 1'b1;
    state_s     = ILL_STATE;
    cond_pass_s = 1'b0;
    illegal_s   = 1'b1;
    if (dec_s.illegal || nv_s) begin
      state_s     = ILL_STATE;
      cond_pass_s = 1'b0;
      illegal_s   = 1'b1;
    end else if (!pass_s) begin
      state_s     = NOP_STATE;
      cond_pass_s = 1'b0;
      illegal_s   = 1'b0;
    end else begin
      state_s     = STATE_W'(dec_s.state);
      cond_pass_s = 1'b1;
      illegal_s   = 1'b0;
    end
  end

  decoder_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   ({state_s, cond_pass_s, illegal_s}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data_s),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_state     = out_data_s[PW-1:2];
  assign out_cond_pass = out_data_s[1];
  assign out_illegal   = out_data_s[0];
  assign xfer_s        = out_valid && out_ready;
  assign decode_count  = dec_cnt_r;
  assign illegal_count = ill_cnt_r;

  // Saturating handshake statistics; flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_cnt_r <= '0;
      ill_cnt_r <= '0;
    end else begin
      if (xfer_s && (dec_cnt_r != CNT_MAX)) begin
        dec_cnt_r <= dec_cnt_r + CNT_ONE;
      end
      if (xfer_s && out_illegal && (ill_cnt_r != CNT_MAX)) begin
        ill_cnt_r <= ill_cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Directed, table-driven bench for instr_decoder_pipe with a second CNT_W=4
// instance sharing the stimulus to exercise counter saturation.
module tb_instr_decoder_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] in_instr;
  logic [3:0]  in_flags;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  out_state;
  logic        out_cond_pass;
  logic        out_illegal;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] decode_count;
  logic [15:0] illegal_count;

  logic        s_in_ready;
  logic [6:0]  s_out_state;
  logic        s_out_cond_pass;
  logic        s_out_illegal;
  logic        s_out_valid;
  logic [3:0]  s_decode_count;
  logic [3:0]  s_illegal_count;

  int n_cmp = 0;
  int n_err = 0;

  instr_decoder_pipe dut (
    .clk(clk), .reset(reset), .flush(flush), .in_instr(in_instr), .in_flags(in_flags),
    .in_valid(in_valid), .in_ready(in_ready), .out_state(out_state),
    .out_cond_pass(out_cond_pass), .out_illegal(out_illegal), .out_valid(out_valid),
    .out_ready(out_ready), .decode_count(decode_count), .illegal_count(illegal_count)
  );

  instr_decoder_pipe #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .flush(flush), .in_instr(in_instr), .in_flags(in_flags),
    .in_valid(in_valid), .in_ready(s_in_ready), .out_state(s_out_state),
    .out_cond_pass(s_out_cond_pass), .out_illegal(s_out_illegal), .out_valid(s_out_valid),
    .out_ready(out_ready), .decode_count(s_decode_count), .illegal_count(s_illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  flags;
    logic [6:0]  state;
    logic        pass;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic addv(input logic [31:0] i, input logic [3:0] f, input logic [6:0] s,
                      input logic p, input logic il);
    vec_t v;
    v.instr = i; v.flags = f; v.state = s; v.pass = p; v.ill = il;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [31:0] i, input logic [3:0] f);
    in_instr = i;
    in_flags = f;
    in_valid = 1'b1;
  endtask

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  initial begin
    int exp_ill;
    int base_dec;
    int base_ill;
    int n;

    reset = 1'b1; flush = 1'b0; in_instr = 32'd0; in_flags = 4'd0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_state", out_state, 0);
    chk("rst_cond_pass", out_cond_pass, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dec_cnt", decode_count, 0);
    chk("rst_ill_cnt", illegal_count, 0);

    // flags are NZCV
    addv(32'hE5112000, 4'b0000, 7'd122, 1'b1, 1'b0);
    addv(32'hE4112000, 4'b0000, 7'd106, 1'b1, 1'b0);
    addv(32'hE5012000, 4'b0000, 7'd121, 1'b1, 1'b0);
    addv(32'hE5B12000, 4'b0000, 7'd110, 1'b1, 1'b0);
    addv(32'hE6D12000, 4'b0000, 7'd68,  1'b1, 1'b0);
    addv(32'hE7C02000, 4'b0000, 7'd83,  1'b1, 1'b0);
    addv(32'hE6900000, 4'b0000, 7'd70,  1'b1, 1'b0);
    addv(32'h02800005, 4'b0000, 7'd1,   1'b0, 1'b0);
    addv(32'h02800005, 4'b0100, 7'd7,   1'b1, 1'b0);
    addv(32'h03800005, 4'b0100, 7'd123, 1'b1, 1'b0);
    addv(32'hE0810002, 4'b0000, 7'd5,   1'b1, 1'b0);
    addv(32'hE0810102, 4'b0000, 7'd6,   1'b1, 1'b0);
    addv(32'hE0910000, 4'b0000, 7'd10,  1'b1, 1'b0);
    addv(32'hE0910080, 4'b0000, 7'd11,  1'b1, 1'b0);
    addv(32'hE0910010, 4'b0000, 7'd0,   1'b0, 1'b1);
    addv(32'hE3A00000, 4'b0000, 7'd9,   1'b1, 1'b0);
    addv(32'hE3400000, 4'b0000, 7'd8,   1'b1, 1'b0);
    addv(32'hE3B00000, 4'b0000, 7'd13,  1'b1, 1'b0);
    addv(32'hE2000000, 4'b0000, 7'd127, 1'b1, 1'b0);
    addv(32'hE2100000, 4'b0000, 7'd126, 1'b1, 1'b0);
    addv(32'hE2400000, 4'b0000, 7'd125, 1'b1, 1'b0);
    addv(32'hE2500000, 4'b0000, 7'd124, 1'b1, 1'b0);
    addv(32'hE3500000, 4'b0000, 7'd0,   1'b0, 1'b1);
    addv(32'hEA000010, 4'b0000, 7'd30,  1'b1, 1'b0);
    addv(32'hEB000000, 4'b0000, 7'd31,  1'b1, 1'b0);
    addv(32'h1A000000, 4'b0100, 7'd1,   1'b0, 1'b0);
    addv(32'h1A000000, 4'b0000, 7'd30,  1'b1, 1'b0);
    addv(32'h2A000000, 4'b0010, 7'd30,  1'b1, 1'b0);
    addv(32'h3A000000, 4'b0010, 7'd1,   1'b0, 1'b0);
    addv(32'h4A000000, 4'b0000, 7'd1,   1'b0, 1'b0);
    addv(32'h5A000000, 4'b0000, 7'd30,  1'b1, 1'b0);
    addv(32'h6A000000, 4'b0001, 7'd30,  1'b1, 1'b0);
    addv(32'h7A000000, 4'b0001, 7'd1,   1'b0, 1'b0);
    addv(32'h8A000000, 4'b0010, 7'd30,  1'b1, 1'b0);
    addv(32'h9A000000, 4'b0010, 7'd1,   1'b0, 1'b0);
    addv(32'hAA000000, 4'b1001, 7'd30,  1'b1, 1'b0);
    addv(32'hB0810002, 4'b1000, 7'd5,   1'b1, 1'b0);
    addv(32'hCA000000, 4'b1001, 7'd30,  1'b1, 1'b0);
    addv(32'hCA000000, 4'b1000, 7'd1,   1'b0, 1'b0);
    addv(32'hDA000000, 4'b0100, 7'd30,  1'b1, 1'b0);
    addv(32'hF5000000, 4'b0000, 7'd0,   1'b0, 1'b1);
    addv(32'hE6000010, 4'b0000, 7'd0,   1'b0, 1'b1);
    addv(32'hE8000000, 4'b0000, 7'd0,   1'b0, 1'b1);
    addv(32'h06000010, 4'b0000, 7'd0,   1'b0, 1'b1);

    // Streamed at full rate: each output is checked the cycle after acceptance.
    n = vecs.size();
    exp_ill = 0;
    drive(vecs[0].instr, vecs[0].flags);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_valid", i-1), out_valid, 1);
      chk($sformatf("v%0d_state", i-1), out_state, vecs[i-1].state);
      chk($sformatf("v%0d_pass", i-1), out_cond_pass, vecs[i-1].pass);
      chk($sformatf("v%0d_ill", i-1), out_illegal, vecs[i-1].ill);
      chk($sformatf("v%0d_dcnt", i-1), decode_count, i-1);
      chk($sformatf("v%0d_icnt", i-1), illegal_count, exp_ill);
      chk($sformatf("v%0d_small_dcnt", i-1), s_decode_count, sat15(i-1));
      if (vecs[i-1].ill) exp_ill++;
      if (i < n) drive(vecs[i].instr, vecs[i].flags);
      else in_valid = 1'b0;
    end
    @(negedge clk);
    chk("tbl_drain_valid", out_valid, 0);
    chk("tbl_dcnt", decode_count, n);
    chk("tbl_icnt", illegal_count, exp_ill);
    chk("tbl_small_dcnt_sat", s_decode_count, 15);
    base_dec = n;
    base_ill = exp_ill;

    // Backpressure: three words offered with out_ready low for three cycles.
    out_ready = 1'b0;
    drive(32'hE0810002, 4'b0000);
    @(negedge clk);
    chk("bp_in_ready_1", in_ready, 1);
    chk("bp_state_a", out_state, 5);
    drive(32'hE0810102, 4'b0000);
    @(negedge clk);
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_hold_a_1", out_state, 5);
    drive(32'hEA000010, 4'b0000);
    @(negedge clk);
    chk("bp_in_ready_still", in_ready, 0);
    chk("bp_hold_a_2", out_state, 5);
    chk("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_state_b", out_state, 6);
    chk("bp_in_ready_free", in_ready, 1);
    @(negedge clk);
    chk("bp_state_c", out_state, 30);
    chk("bp_valid_c", out_valid, 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drain", out_valid, 0);
    chk("bp_dcnt", decode_count, base_dec + 3);
    base_dec = base_dec + 3;

    // Flush with both slots occupied, plus a word offered during the flush.
    out_ready = 1'b0;
    drive(32'hE0810002, 4'b0000);
    @(negedge clk);
    drive(32'hEA000010, 4'b0000);
    @(negedge clk);
    chk("fl_full", in_ready, 0);
    flush = 1'b1;
    drive(32'hEB000000, 4'b0000);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("fl_valid_cleared", out_valid, 0);
    chk("fl_dcnt", decode_count, base_dec);
    @(negedge clk);
    chk("fl_skid_cleared", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    flush = 1'b1;
    drive(32'hEB000000, 4'b0000);
    #1;
    chk("fl_in_ready_low", in_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_dropped", out_valid, 0);
    @(negedge clk);
    chk("fl_dropped_2", out_valid, 0);
    chk("fl_dcnt_2", decode_count, base_dec);
    chk("fl_icnt", illegal_count, base_ill);

    // Reset while the pipe is stalled and full.
    out_ready = 1'b0;
    drive(32'hE0810002, 4'b0000);
    @(negedge clk);
    drive(32'hEA000010, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rs_valid", out_valid, 0);
    chk("rs_state", out_state, 0);
    chk("rs_pass", out_cond_pass, 0);
    chk("rs_ill", out_illegal, 0);
    chk("rs_in_ready", in_ready, 1);
    chk("rs_dcnt", decode_count, 0);
    chk("rs_icnt", illegal_count, 0);
    chk("rs_small_dcnt", s_decode_count, 0);

    // Saturation: 20 illegal words through the CNT_W=4 instance.
    out_ready = 1'b1;
    drive(32'hF5000000, 4'b0000);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("sat%0d_ill", k), s_out_illegal, 1);
      chk($sformatf("sat%0d_small_dcnt", k), s_decode_count, sat15(k-1));
      chk($sformatf("sat%0d_small_icnt", k), s_illegal_count, sat15(k-1));
      chk($sformatf("sat%0d_dcnt", k), decode_count, k-1);
      if (k == 20) in_valid = 1'b0;
    end
    @(negedge clk);
    chk("sat_small_final", s_decode_count, 15);
    chk("sat_small_ill_final", s_illegal_count, 15);
    chk("sat_dcnt_final", decode_count, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
